// File: rtl/alu_status_reg.sv
// Registered ALU status word with sticky overflow/carry, a saturating overflow-event
// counter, and a valid/ready condition-code evaluator that answers against the held status.
module alu_status_reg #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_zero,
  input  logic             in_sign,
  input  logic             in_parity,
  input  logic             in_overflow,
  input  logic             in_carry,
  input  logic             clr_sticky,
  input  logic             cond_req,
  input  logic [3:0]       cond_code,
  input  logic             cond_ready,
  output logic [4:0]       status,
  output logic             sticky_ovf,
  output logic             sticky_carry,
  output logic [CNT_W-1:0] ovf_count,
  output logic             cond_valid,
  output logic             cond_true
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [4:0]       status_q, status_d;
  logic             sticky_ovf_q, sticky_ovf_d;
  logic             sticky_carry_q, sticky_carry_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
  logic [0:0]       state_q, state_d;
  logic             cond_true_q, cond_true_d;
  logic             cond_eval;
  logic             ovf_event;
  logic             f_z, f_s, f_p, f_v, f_c, f_lt;

  assign f_z  = status_q[0];
  assign f_s  = status_q[1];
  assign f_p  = status_q[2];
  assign f_v  = status_q[3];
  assign f_c  = status_q[4];
  assign f_lt = f_s ^ f_v;

  // Evaluated against the registered status, so a same-edge in_valid is not seen.
  always_comb begin
    cond_eval = 1'b0;
    case (cond_code)
      4'd0:    cond_eval = 1'b1;
      4'd1:    cond_eval = f_z;
      4'd2:    cond_eval = ~f_z;
      4'd3:    cond_eval = f_s;
      4'd4:    cond_eval = ~f_s;
      4'd5:    cond_eval = f_c;
      4'd6:    cond_eval = ~f_c;
      4'd7:    cond_eval = f_v;
      4'd8:    cond_eval = ~f_v;
      4'd9:    cond_eval = f_p;
      4'd10:   cond_eval = ~f_p;
      4'd11:   cond_eval = f_lt;
      4'd12:   cond_eval = ~f_lt;
      4'd13:   cond_eval = ~f_z & ~f_lt;
      4'd14:   cond_eval = f_z | f_lt;
      default: cond_eval = 1'b0;
    endcase
  end

  assign ovf_event = in_valid & in_overflow;

  always_comb begin
    status_d       = status_q;
    sticky_ovf_d   = sticky_ovf_q;
    sticky_carry_d = sticky_carry_q;
    ovf_count_d    = ovf_count_q;
    if (in_valid) begin
      status_d = {in_carry, in_overflow, in_parity, in_sign, in_zero};
    end
    if (clr_sticky) begin
      sticky_ovf_d   = 1'b0;
      sticky_carry_d = 1'b0;
      ovf_count_d    = '0;
    end
    // A set arriving with a clear survives it; the counter restarts at 1.
    if (ovf_event) begin
      sticky_ovf_d = 1'b1;
      if (clr_sticky) begin
        ovf_count_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (ovf_count_q != CNT_MAX) begin
        ovf_count_d = ovf_count_q + 1'b1;
      end
    end
    if (in_valid && in_carry) begin
      sticky_carry_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cond_true_d = cond_true_q;
    case (state_q)
      S_IDLE: begin
        if (cond_req) begin
          state_d     = S_RESP;
          cond_true_d = cond_eval;
        end
      end
      default: begin
        if (cond_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q       <= '0;
      sticky_ovf_q   <= 1'b0;
      sticky_carry_q <= 1'b0;
      ovf_count_q    <= '0;
      state_q        <= S_IDLE;
      cond_true_q    <= 1'b0;
    end else begin
      status_q       <= status_d;
      sticky_ovf_q   <= sticky_ovf_d;
      sticky_carry_q <= sticky_carry_d;
      ovf_count_q    <= ovf_count_d;
      state_q        <= state_d;
      cond_true_q    <= cond_true_d;
    end
  end

  assign status       = status_q;
  assign sticky_ovf   = sticky_ovf_q;
  assign sticky_carry = sticky_carry_q;
  assign ovf_count    = ovf_count_q;
  assign cond_valid   = (state_q == S_RESP);
  assign cond_true    = cond_true_q;

endmodule

// File: doc/alu_status_reg.md
# alu_status_reg

Registered status stage directly downstream of the ALU flag generator. It captures the five combinational flags (zero, sign, parity, overflow, carry) whenever the ALU reports a valid result, and holds them as the architectural status word. It also keeps sticky overflow/carry bits with a saturating overflow-event counter. A handshaked condition-code evaluator answers branch/compare queries against the held status.

## Interface
- CNT_W, 8, width of the overflow-event counter (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU result valid this cycle; flags sampled on this edge
- in_zero, in_sign, in_parity, in_overflow, in_carry  in  1 each  flags from the flag generator
- clr_sticky  in  1  clears sticky_ovf, sticky_carry, ovf_count
- cond_req  in  1  condition query request (accepted only in IDLE)
- cond_code  in  4  condition selector, sampled with accepted cond_req
- cond_ready  in  1  consumer accepts the response
- status  out  5  {carry, overflow, parity, sign, zero}, registered
- sticky_ovf, sticky_carry  out  1 each  accumulated flags
- ovf_count  out  CNT_W  saturating count of in_valid cycles with in_overflow=1
- cond_valid  out  1  response valid
- cond_true  out  1  condition result, meaningful while cond_valid=1

## Operation
- status: on edge with in_valid=1, loads {in_carry, in_overflow, in_parity, in_sign, in_zero}; otherwise holds.
- sticky_ovf/sticky_carry: set on in_valid & corresponding flag; cleared by clr_sticky. Same-cycle set and clr_sticky: set wins (bit = 1).
- ovf_count: +1 on in_valid & in_overflow, saturates at 2^CNT_W−1 (no wrap). clr_sticky resets to 0; same-cycle increment and clear yields 1.
- Condition codes (Z,S,P,V,C from status): 0 always; 1 Z; 2 !Z; 3 S; 4 !S; 5 C; 6 !C; 7 V; 8 !V; 9 P; 10 !P; 11 S^V (signed lt); 12 !(S^V) (ge); 13 !Z & !(S^V) (gt); 14 Z | (S^V) (le); 15 never.
- FSM, two states:
  - IDLE: cond_valid=0. On cond_req=1, evaluate cond_code against the status register contents before this edge's in_valid update, latch result into cond_true, go to RESP.
  - RESP: cond_valid=1, cond_true stable. cond_ready=1 → IDLE; else stay. cond_req in RESP ignored (not queued).
- Status/sticky/counter updates proceed independently of FSM state; a held response does not change when status changes.

## Timing
- Reset (async, immediate): status=0, sticky_ovf=0, sticky_carry=0, ovf_count=0, cond_valid=0, cond_true=0, FSM=IDLE. Reset mid-response drops cond_valid with no completion.
- status latency: 1 cycle (visible after the in_valid edge).
- Query latency: cond_req accepted at edge N → cond_valid=1 from N to completion; earliest completion at edge N+1 with cond_ready=1.
- Max throughput: one query per 2 cycles (RESP→IDLE, next request accepted the following edge).
- cond_req and in_valid on the same edge: query sees old status; new status visible to the next query.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Reset: assert rst asynchronously mid-cycle with cond_valid=1, status=5'b11111, ovf_count=5 → all outputs 0 immediately, FSM IDLE after release.
- Capture: in_valid with Z=1,P=1, rest 0 → status=5'b00101 next cycle; in_valid=0 with different flags → status unchanged.
- Sticky/counter: 3 in_valid pulses with V=1, then clr_sticky together with a 4th V=1 pulse → ovf_count 3 then 1, sticky_ovf stays 1; with CNT_W=2, 5 overflow pulses → ovf_count=3 (saturated).
- Conditions: status S=1,V=0,Z=0 → codes 11,12,13,14 return 1,0,0,1; codes 0/15 return 1/0.
- Simultaneous: status Z=0, same edge cond_req code 1 and in_valid with Z=1 → cond_true=0; next query code 1 → 1.
- Handshake: cond_ready held low 4 cycles → cond_valid high and cond_true stable throughout while status changes and extra cond_req pulses are ignored; ready=1 → cond_valid=0 next cycle, new request accepted the cycle after.
